// File: rtl/rom_download_pkg.sv
// Shared types and constants for the ROM download packer.
package rom_download_pkg;

  localparam int unsigned LANES    = 4;
  localparam int unsigned DATA_W   = 8 * LANES;
  localparam int unsigned SDRAM_AW = 23;

  typedef enum logic {
    IDLE,
    REQ
  } wr_state_e;

  typedef struct packed {
    logic [SDRAM_AW-1:0] addr;
    logic [DATA_W-1:0]   data;
  } fifo_entry_t;

  // Expand per-lane valid bits into a byte mask over the data word.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] lanes);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      mask[8*k +: 8] = {8{lanes[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/rom_download_packer_if.sv
// SDRAM controller request/acknowledge write port.
interface rom_download_packer_if;
  import rom_download_pkg::*;

  logic [SDRAM_AW-1:0] sdram_addr;
  logic [DATA_W-1:0]   sdram_data;
  logic                sdram_we;
  logic                sdram_req;
  logic                sdram_ack;

  modport master (
    output sdram_addr,
    output sdram_data,
    output sdram_we,
    output sdram_req,
    input  sdram_ack
  );

  modport slave (
    input  sdram_addr,
    input  sdram_data,
    input  sdram_we,
    input  sdram_req,
    output sdram_ack
  );

endinterface

// File: rtl/rom_download_packer_fifo.sv
// Word FIFO accepting up to two ordered pushes per cycle; exposes head and head+1.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     push2_i,
  input  logic [WIDTH-1:0]         push2_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         next_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    push_n;
  logic             empty_q;

  always_comb begin
    push_n   = CW'(push_i) + CW'(push_i & push2_i);
    wr_ptr_d = wr_ptr_q + PW'(push_n);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + push_n - CW'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
    end
  end

  // Storage is not reset; pointer reset discards contents.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
    if (push_i && push2_i) begin
      mem_q[wr_ptr_q + PW'(1)] <= push2_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + PW'(1)];
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/rom_download_packer.sv
// Packs the HPS download byte stream into 32-bit words and writes them to SDRAM.
module rom_download_packer
  import rom_download_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [ADDR_WIDTH-1:0] ioctl_addr,
  input  logic [7:0]            ioctl_data,
  output logic                  ioctl_wait,
  rom_download_packer_if.master sdram,
  output logic                  rom_ready
);

  localparam int unsigned WA_W    = ADDR_WIDTH - 2;
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  function automatic fifo_entry_t make_entry(input logic [WA_W-1:0] waddr,
                                             input logic [DATA_W-1:0] data);
    fifo_entry_t e;
    e.addr = SDRAM_AW'({waddr, 1'b0});
    e.data = data;
    return e;
  endfunction

  logic              dl_q;
  logic              dl_rise, dl_fall, byte_en;
  logic [WA_W-1:0]   byte_waddr;
  logic [1:0]        byte_lane;

  logic              pend_q, pend_d;
  logic [WA_W-1:0]   pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [LANES-1:0]  pend_lanes_q, pend_lanes_d;

  logic              flush_push, done_push;
  logic [DATA_W-1:0] base_data, merged_data;
  logic [LANES-1:0]  base_lanes, merged_lanes;
  fifo_entry_t       flush_entry, done_entry;

  logic              fifo_push, fifo_push2, fifo_pop, fifo_empty;
  logic [CW-1:0]     fifo_count;
  fifo_entry_t       fifo_push_data, fifo_push2_data, head, nxt;
  logic [ENTRY_W-1:0] head_raw, next_raw;

  wr_state_e           state_q, state_d;
  logic                req_q, req_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wait_q;
  logic                ready_q, ready_d;

  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign byte_en    = ioctl_wr & ioctl_download;
  assign byte_waddr = ioctl_addr[ADDR_WIDTH-1:2];
  assign byte_lane  = ioctl_addr[1:0];

  // Merge bytes into the pending word; a single byte may flush the old word and complete a new one.
  always_comb begin : packer_comb
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_lanes_d = pend_lanes_q;
    flush_push   = 1'b0;
    done_push    = 1'b0;
    base_data    = '0;
    base_lanes   = '0;
    merged_data  = '0;
    merged_lanes = '0;
    flush_entry  = make_entry(pend_addr_q, pend_data_q & lane_mask(pend_lanes_q));
    if (byte_en) begin
      if (pend_q && (byte_waddr == pend_addr_q)) begin
        base_data  = pend_data_q;
        base_lanes = pend_lanes_q;
      end else if (pend_q) begin
        flush_push = 1'b1;
      end
      merged_data                          = base_data;
      merged_data[{byte_lane, 3'b000} +: 8] = ioctl_data;
      merged_lanes = base_lanes | (LANES'(1) << byte_lane);
      if (byte_lane == 2'd3) begin
        done_push = 1'b1;
        pend_d    = 1'b0;
      end else begin
        pend_d       = 1'b1;
        pend_addr_d  = byte_waddr;
        pend_data_d  = merged_data;
        pend_lanes_d = merged_lanes;
      end
    end else if (dl_fall && pend_q) begin
      flush_push = 1'b1;
      pend_d     = 1'b0;
    end
    done_entry = make_entry(byte_waddr, merged_data & lane_mask(merged_lanes));
  end

  assign fifo_push       = flush_push | done_push;
  assign fifo_push2      = flush_push & done_push;
  assign fifo_push_data  = flush_push ? flush_entry : done_entry;
  assign fifo_push2_data = done_entry;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (fifo_push),
    .push_data_i  (fifo_push_data),
    .push2_i      (fifo_push2),
    .push2_data_i (fifo_push2_data),
    .pop_i        (fifo_pop),
    .head_o       (head_raw),
    .next_o       (next_raw),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  assign head = head_raw;
  assign nxt  = next_raw;

  // Writer: keep req high across back-to-back entries so no idle cycle separates them.
  always_comb begin : writer_comb
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          addr_d  = head.addr;
          data_d  = head.data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sdram.sdram_ack) begin
          fifo_pop = 1'b1;
          if (fifo_count > CW'(1)) begin
            addr_d = nxt.addr;
            data_d = nxt.data;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : ready_comb
    ready_d = ready_q;
    if (dl_rise) begin
      ready_d = 1'b0;
    end else if (!ioctl_download && !dl_q && !pend_q && fifo_empty && (state_q == IDLE)) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_q         <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_lanes_q <= '0;
      state_q      <= IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      wait_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      dl_q         <= ioctl_download;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pend_lanes_q <= pend_lanes_d;
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wait_q       <= (fifo_count >= CW'(FIFO_DEPTH - 1));
      ready_q      <= ready_d;
    end
  end

  assign sdram.sdram_addr = addr_q;
  assign sdram.sdram_data = data_q;
  assign sdram.sdram_req  = req_q;
  assign sdram.sdram_we   = req_q;
  assign ioctl_wait       = wait_q;
  assign rom_ready        = ready_q;

endmodule
